// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - command-driven 8-bit counter controller
// Prescaled up/down counter with one-shot or auto-reload run modes and a registered terminal match pulse.
module counter_sequencer #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] count,
  output logic             match,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [2:0] OP_LOAD       = 3'd1;
  localparam logic [2:0] OP_SET_TOP    = 3'd2;
  localparam logic [2:0] OP_SET_PRESC  = 3'd3;
  localparam logic [2:0] OP_START_UP   = 3'd4;
  localparam logic [2:0] OP_START_DOWN = 3'd5;
  localparam logic [2:0] OP_STOP       = 3'd6;
  localparam logic [2:0] OP_CLEAR      = 3'd7;

  state_t             st;
  logic [WIDTH-1:0]   cnt;
  logic [WIDTH-1:0]   top;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] pc;
  logic               dir_down;
  logic               reload;
  logic               match_r;

  logic accept;
  logic hold_tick;
  logic tick_en;
  logic terminal;

  assign cmd_ready = ena;
  assign accept    = cmd_valid & ena;

  // Any command that rewrites count, pc or run state pre-empts the tick of that cycle.
  assign hold_tick = accept & (cmd_op == OP_LOAD     || cmd_op == OP_SET_PRESC ||
                               cmd_op == OP_START_UP || cmd_op == OP_START_DOWN ||
                               cmd_op == OP_STOP     || cmd_op == OP_CLEAR);
  assign tick_en   = (st == RUN) & ena & ~hold_tick;
  assign terminal  = dir_down ? (cnt == '0) : (cnt == top);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      cnt      <= '0;
      top      <= '1;
      presc    <= '0;
      pc       <= '0;
      dir_down <= 1'b0;
      reload   <= 1'b0;
      match_r  <= 1'b0;
    end else begin
      match_r <= 1'b0;

      if (tick_en) begin
        if (pc == presc) begin
          pc <= '0;
          if (terminal) begin
            match_r <= 1'b1;
            if (reload) cnt <= dir_down ? top : '0;
            else        st  <= DONE;
          end else begin
            cnt <= dir_down ? cnt - WIDTH'(1) : cnt + WIDTH'(1);
          end
        end else begin
          pc <= pc + PRESC_W'(1);
        end
      end

      if (accept) begin
        case (cmd_op)
          OP_LOAD: begin
            cnt <= cmd_data;
            pc  <= '0;
          end
          OP_SET_TOP: top <= cmd_data;
          OP_SET_PRESC: begin
            presc <= cmd_data[PRESC_W-1:0];
            pc    <= '0;
          end
          OP_START_UP, OP_START_DOWN: begin
            dir_down <= (cmd_op == OP_START_DOWN);
            reload   <= cmd_data[0];
            pc       <= '0;
            st       <= RUN;
          end
          OP_STOP: if (st == RUN) st <= PAUSE;
          OP_CLEAR: begin
            st  <= IDLE;
            cnt <= '0;
            pc  <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign count = cnt;
  assign match = match_r;
  assign busy  = (st == RUN);
  assign done  = (st == DONE);
  assign state = st;

endmodule

// File: tb/tb_counter_sequencer.sv
// tb/tb_counter_sequencer.sv - self-checking bench for counter_sequencer
// Directed scenarios with literal expectations, then randomized commands against a cycle model.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic [7:0] count;
  logic       match;
  logic       busy;
  logic       done;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  counter_sequencer #(.WIDTH(8), .PRESC_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .count     (count),
    .match     (match),
    .busy      (busy),
    .done      (done),
    .state     (state)
  );

  always #5 clk = ~clk;

  // Reference model: state as integer 0..3, counter arithmetic done in int then wrapped.
  int m_count, m_top, m_presc, m_pc, m_state, m_match;
  bit m_down, m_reload;

  task automatic model_reset();
    m_count = 0; m_top = 255; m_presc = 0; m_pc = 0;
    m_state = 0; m_match = 0; m_down = 0; m_reload = 0;
  endtask

  task automatic model_step();
    bit acc;
    bit blocks;
    acc    = cmd_valid && ena;
    blocks = acc && !(cmd_op == 3'd0 || cmd_op == 3'd2);
    m_match = 0;
    if (m_state == 1 && ena && !blocks) begin
      if (m_pc == m_presc) begin
        m_pc = 0;
        if (!m_down) begin
          if (m_count == m_top) begin
            m_match = 1;
            if (m_reload) m_count = 0; else m_state = 3;
          end else m_count = (m_count + 1) % 256;
        end else begin
          if (m_count == 0) begin
            m_match = 1;
            if (m_reload) m_count = m_top; else m_state = 3;
          end else m_count = m_count - 1;
        end
      end else m_pc = m_pc + 1;
    end
    if (acc) begin
      case (cmd_op)
        3'd1: begin m_count = cmd_data; m_pc = 0; end
        3'd2: m_top = cmd_data;
        3'd3: begin m_presc = cmd_data % 16; m_pc = 0; end
        3'd4, 3'd5: begin
          m_down = (cmd_op == 3'd5); m_reload = cmd_data[0]; m_pc = 0; m_state = 1;
        end
        3'd6: if (m_state == 1) m_state = 2;
        3'd7: begin m_state = 0; m_count = 0; m_pc = 0; end
        default: ;
      endcase
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (cmp_en) begin
      chk("m.count", count, m_count);
      chk("m.match", match, m_match);
      chk("m.state", state, m_state);
      chk("m.busy", busy, m_state == 1);
      chk("m.done", done, m_state == 3);
      chk("m.ready", cmd_ready, ena);
    end
  end

  // Caller is at a negedge; command is presented for exactly one posedge.
  task automatic send(input logic [2:0] op, input logic [7:0] d);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 8'd0;
  endtask

  int  held;
  int  nmatch;
  bit  saw_wrap;
  bit  hit;

  initial begin
    rst_n = 1'b0; ena = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst.count", count, 0);
    chk("rst.state", state, 0);
    chk("rst.match", match, 0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    // One-shot up to 5
    send(3'd2, 8'd5);
    send(3'd4, 8'd0);
    chk("t1.start_count", count, 0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("t1.count", count, i);
    end
    @(negedge clk);
    chk("t1.match", match, 1);
    chk("t1.done_state", state, 3);
    chk("t1.hold_top", count, 5);
    @(negedge clk);
    chk("t1.match_drop", match, 0);
    chk("t1.still5", count, 5);

    // Auto-reload 0..3
    send(3'd2, 8'd3);
    send(3'd1, 8'd0);
    send(3'd4, 8'd1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("t2.count", count, k % 4);
      chk("t2.match", match, (k % 4) == 0);
      chk("t2.busy", busy, 1);
    end

    // Prescaled one-shot down from 10
    send(3'd3, 8'd2);
    send(3'd1, 8'd10);
    send(3'd5, 8'd0);
    chk("t3.start", count, 10);
    repeat (3) @(negedge clk);
    chk("t3.first_dec", count, 9);
    nmatch = 0; hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk);
      if (match) nmatch++;
      if (done) hit = 1;
    end
    chk("t3.done", hit, 1);
    chk("t3.matches", nmatch, 1);
    chk("t3.count0", count, 0);

    // STOP / resume / CLEAR
    send(3'd3, 8'd0);
    send(3'd2, 8'd100);
    send(3'd1, 8'd0);
    send(3'd4, 8'd0);
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (count == 7) hit = 1;
      else @(negedge clk);
    end
    chk("t4.reach7", hit, 1);
    send(3'd6, 8'd0);
    for (int i = 0; i < 5; i++) begin
      chk("t4.pause_count", count, 7);
      chk("t4.pause_state", state, 2);
      @(negedge clk);
    end
    send(3'd4, 8'd0);
    chk("t4.restart_hold", count, 7);
    @(negedge clk);
    chk("t4.resume8", count, 8);
    send(3'd7, 8'd0);
    chk("t4.clear_count", count, 0);
    chk("t4.clear_state", state, 0);
    send(3'd1, 8'd99);
    send(3'd4, 8'd0);
    @(negedge clk);
    chk("t4.top_kept_count", count, 100);
    @(negedge clk);
    chk("t4.top_kept_match", match, 1);
    chk("t4.top_kept_done", done, 1);

    // Load above top wraps through zero
    send(3'd2, 8'd5);
    send(3'd1, 8'd200);
    send(3'd4, 8'd0);
    hit = 0; saw_wrap = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (count == 0) saw_wrap = 1;
      if (done) hit = 1;
    end
    chk("t5.done", hit, 1);
    chk("t5.wrapped", saw_wrap, 1);
    chk("t5.count", count, 5);

    // ena freeze with a pending command
    send(3'd2, 8'd50);
    send(3'd1, 8'd0);
    send(3'd4, 8'd1);
    repeat (10) @(negedge clk);
    chk("t5.pre_freeze", count, 10);
    ena = 1'b0;
    cmd_valid = 1'b1; cmd_op = 3'd7;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5.frozen", count, 10);
      chk("t5.ready0", cmd_ready, 0);
      chk("t5.busy", busy, 1);
    end
    cmd_valid = 1'b0; cmd_op = 3'd0; ena = 1'b1;
    @(negedge clk);
    chk("t5.resume", count, 11);

    // Asynchronous reset while running
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6.count", count, 0);
    chk("t6.state", state, 0);
    chk("t6.match", match, 0);
    chk("t6.busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      ena       = ($urandom % 8) != 0;
      cmd_valid = ($urandom % 3) == 0;
      cmd_op    = 3'($urandom % 8);
      cmd_data  = 8'($urandom % 256);
      if (cmd_op == 3'd2) cmd_data = 8'($urandom_range(0, 12));
      if (cmd_op == 3'd3 && ($urandom % 2) == 0) cmd_data = 8'($urandom % 3);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Command-driven controller for the 8-bit demo counter datapath. It loads and clears the count, sets direction and terminal value, applies a programmable prescaler, and runs the counter in one-shot or auto-reload mode. It reports a one-cycle match pulse and run status. Commands arrive over a valid/ready interface driven from the dedicated input pins by the top-level wrapper.

Parameters:
WIDTH, 8, counter, terminal-value and cmd_data width
PRESC_W, 4, prescaler divide-register width (tick every presc+1 enabled cycles)

Ports:
clk  input  1  system clock, all state updates on posedge
rst_n  input  1  asynchronous active-low reset
ena  input  1  global enable; when 0, no ticks and cmd_ready=0
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at posedge clk
cmd_op  input  3  0 NOP, 1 LOAD, 2 SET_TOP, 3 SET_PRESC, 4 START_UP, 5 START_DOWN, 6 STOP, 7 CLEAR
cmd_data  input  WIDTH  operand; START_* uses bit0 as reload flag
count  output  WIDTH  current counter value (registered)
match  output  1  one-cycle pulse on terminal tick
busy  output  1  high in RUN
done  output  1  high in DONE
state  output  2  0 IDLE, 1 RUN, 2 PAUSE, 3 DONE

Behaviour:
- Reset (async, rst_n=0): count=0, top=all ones, presc=0, prescaler counter pc=0, dir=up, reload=0, state=IDLE, match=0. cmd_ready is combinational, so it is 0 while ena=0.
- cmd_ready = ena, in every state. A command is accepted when cmd_valid & cmd_ready are both high. All registered effects occur at that edge.
- LOAD: count<=cmd_data; pc<=0; state unchanged.
- SET_TOP: top<=cmd_data. SET_PRESC: presc<=cmd_data[PRESC_W-1:0]; pc<=0.
- START_UP/START_DOWN: dir latched; reload<=cmd_data[0]; pc<=0; state<=RUN from IDLE, PAUSE or DONE. In RUN it restarts with the new dir/reload. count is untouched.
- STOP: RUN->PAUSE; count and pc hold. No effect in other states.
- CLEAR: any state->IDLE; count=0; pc=0; top and presc are retained.
- Tick: occurs in RUN with ena=1 and no count-affecting command (LOAD, CLEAR, START_*, SET_PRESC, STOP) accepted that cycle.
  - pc==presc -> tick, pc<=0.
  - Otherwise pc<=pc+1.
  - presc=0 means a tick every cycle.
- Up tick:
  - count==top: match=1. If reload, count<=0 and stay in RUN. Else state<=DONE and count holds top.
  - Otherwise count<=count+1, wrapping mod 2^WIDTH. Terminal is detected on equality only, so a count loaded above top wraps through 0 up to top.
- Down tick:
  - count==0: match=1. If reload, count<=top. Else state<=DONE and count holds 0.
  - Otherwise count<=count-1.
- match is registered: high exactly the cycle after the terminal-tick edge, for one cycle. It is 0 otherwise, including after CLEAR.
- Latency: START accepted at edge N with presc=0 gives the first count change at edge N+1. With presc=P, count changes at edges N+P+1, N+2P+2, and so on.
- top=0 in up mode: every tick is terminal.
- START from DONE without LOAD: the first tick is immediately terminal.
- ena=0 freezes pc, count and state, and blocks commands. Resuming ena continues from the frozen pc.
- Reset mid-run returns all registers to reset values immediately, regardless of clk.

Test Plan:
- Reset, SET_TOP 5, START_UP reload=0, presc=0 -> count 1,2,3,4,5 on successive cycles; match pulse on the cycle after count=5 is sampled; state=DONE; count stays 5.
- SET_TOP 3, LOAD 0, START_UP reload=1 -> count 0,1,2,3,0,1,...; match every 4th cycle; busy stays 1.
- SET_PRESC 2, LOAD 10, START_DOWN reload=0 -> count decrements once every 3 cycles to 0; match asserts once; done=1.
- Running up, STOP at count=7, hold 5 cycles, START_UP -> count frozen at 7 in PAUSE, then resumes at 8. Then CLEAR -> count=0, state=IDLE, top unchanged.
- LOAD 200 with top=5, START_UP -> wraps 255->0 and reaches 5, then match. Separately, drop ena for 4 cycles mid-run -> count and pc frozen, cmd_ready=0.
- Assert rst_n=0 asynchronously between clock edges while RUN -> outputs reset immediately (count=0, state=IDLE, match=0).
